// File: rtl/pingpong_rd_sched_pkg.sv
// Shared types and defaults for the ping-pong buffer read scheduler.
// Pure declarations: no logic, no latency, no flow control.
package pingpong_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TAKE,
    STREAM,
    DISCARD,
    DONE
  } rd_sched_state_e;

  localparam int SAMPLE_W_DEF = 16;
  localparam int BUF_LEN_DEF  = 256;
  localparam int WDOG_LIMIT   = 1024;

endpackage

// File: rtl/pingpong_rd_sched_rr_arbiter.sv
// Round-robin pick of the first requester at or after ptr; one-hot grant plus its index.
// Purely combinational (zero latency); no flow control of its own.
module rr_arbiter #(
  parameter int NUM_CONS = 2,
  parameter int PTR_W    = 1
) (
  input  logic [NUM_CONS-1:0] req,
  input  logic [PTR_W-1:0]    ptr,
  output logic [NUM_CONS-1:0] gnt,
  output logic [PTR_W-1:0]    idx
);

  logic found;
  int   cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NUM_CONS; i++) begin
      cand = (int'(ptr) + i) % NUM_CONS;
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = PTR_W'(cand);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pingpong_rd_sched.sv
// Drains full ping-pong buffers to round-robin consumers, discarding unclaimed ones after a timeout.
// Data path is a zero-latency pass-through; read ready follows the owner's ready. RD_SCHED_WDOG_EN adds a stall watchdog.
module pingpong_rd_sched
  import pingpong_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int BUF_LEN  = BUF_LEN_DEF,
  parameter int NUM_CONS = 2,
  parameter int DROP_TMO = 64,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                buf_ready_i,
  input  logic                buf_id_i,
  output logic                buf_take_o,
  input  logic [SAMPLE_W-1:0] rd_data_i,
  input  logic                rd_valid_i,
  input  logic                rd_last_i,
  output logic                rd_ready_o,
  input  logic [NUM_CONS-1:0] req_i,
  output logic [NUM_CONS-1:0] gnt_o,
  output logic [SAMPLE_W-1:0] out_data_o,
  output logic [NUM_CONS-1:0] out_valid_o,
  input  logic [NUM_CONS-1:0] out_ready_i,
  output logic                out_last_o,
  output logic                out_buf_id_o,
  output logic                busy_o,
  output logic [CNT_W-1:0]    frame_cnt_o,
  output logic [CNT_W-1:0]    drop_cnt_o,
  output logic                len_err_o
`ifdef RD_SCHED_WDOG_EN
  ,
  output logic                wdog_abort_o
`endif
);

  localparam int PTR_W  = (NUM_CONS > 1) ? $clog2(NUM_CONS) : 1;
  localparam int BCNT_W = $clog2(BUF_LEN + 1);
  localparam int TMO_W  = (DROP_TMO > 1) ? $clog2(DROP_TMO) : 1;
  localparam logic [BCNT_W-1:0] BUF_LEN_C = BCNT_W'(BUF_LEN);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(DROP_TMO - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUM_CONS - 1);

  rd_sched_state_e     state_q, state_d;
  logic [NUM_CONS-1:0] gnt_q, arb_gnt;
  logic [PTR_W-1:0]    owner_q, rr_ptr_q, arb_idx;
  logic [TMO_W-1:0]    tmo_q;
  logic [BCNT_W-1:0]   beat_q, beat_inc;
  logic                discard_q, buf_id_q, len_err_q;
  logic [CNT_W-1:0]    frame_cnt_q, drop_cnt_q;
  logic                beat, wdog_trip;

  rr_arbiter #(.NUM_CONS(NUM_CONS), .PTR_W(PTR_W)) u_arb (
    .req(req_i),
    .ptr(rr_ptr_q),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );

`ifdef RD_SCHED_WDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_LIMIT - 1);
  logic [15:0] wdog_q;
  logic        wdog_abort_q;
  assign wdog_trip    = (state_q == STREAM) && rd_valid_i && !out_ready_i[owner_q] && (wdog_q == WDOG_LAST);
  assign wdog_abort_o = wdog_abort_q;
`else
  assign wdog_trip = 1'b0;
`endif

  // Beat counter pins at BUF_LEN so a runaway frame cannot wrap back to a "correct" length.
  assign beat_inc = (beat_q == BUF_LEN_C) ? beat_q : beat_q + BCNT_W'(1);
  assign beat     = rd_valid_i && rd_ready_o;

  always_comb begin
    state_d     = state_q;
    buf_take_o  = 1'b0;
    rd_ready_o  = 1'b0;
    out_valid_o = '0;
    out_data_o  = '0;
    out_last_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (buf_ready_i && ((|req_i) || tmo_q == TMO_LAST)) state_d = TAKE;
      end
      TAKE: begin
        buf_take_o = 1'b1;
        state_d    = discard_q ? DISCARD : STREAM;
      end
      STREAM: begin
        rd_ready_o           = out_ready_i[owner_q];
        out_data_o           = rd_data_i;
        out_valid_o[owner_q] = rd_valid_i;
        out_last_o           = rd_last_i && rd_valid_i;
        if (rd_valid_i && rd_ready_o && rd_last_i) state_d = DONE;
        else if (wdog_trip)                          state_d = DISCARD;
      end
      DISCARD: begin
        rd_ready_o = 1'b1;
        if (rd_valid_i && rd_last_i) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      tmo_q       <= '0;
      beat_q      <= '0;
      discard_q   <= 1'b0;
      buf_id_q    <= 1'b0;
      len_err_q   <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          beat_q <= '0;
          if (buf_ready_i && |req_i) begin
            gnt_q     <= arb_gnt;
            owner_q   <= arb_idx;
            buf_id_q  <= buf_id_i;
            discard_q <= 1'b0;
            tmo_q     <= '0;
          end else if (buf_ready_i && tmo_q == TMO_LAST) begin
            gnt_q     <= '0;
            buf_id_q  <= buf_id_i;
            discard_q <= 1'b1;
            tmo_q     <= '0;
          end else if (buf_ready_i) begin
            tmo_q <= tmo_q + TMO_W'(1);
          end else begin
            tmo_q <= '0;
          end
        end
        STREAM: begin
          if (beat) begin
            beat_q <= beat_inc;
            if ((beat_q == BUF_LEN_C) || (rd_last_i && beat_inc != BUF_LEN_C)) len_err_q <= 1'b1;
          end
          if (wdog_trip) discard_q <= 1'b1;
        end
        DISCARD: begin
          if (rd_valid_i && rd_last_i && drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
        DONE: begin
          gnt_q <= '0;
          if (!discard_q) begin
            if (frame_cnt_q != {CNT_W{1'b1}}) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            rr_ptr_q <= (owner_q == PTR_LAST) ? '0 : owner_q + PTR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RD_SCHED_WDOG_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdog_q       <= '0;
      wdog_abort_q <= 1'b0;
    end else if (state_q == STREAM && rd_valid_i && !out_ready_i[owner_q] && !wdog_trip) begin
      wdog_q <= wdog_q + 16'd1;
    end else begin
      wdog_q <= '0;
      if (wdog_trip) wdog_abort_q <= 1'b1;
    end
  end
`endif

  assign gnt_o        = gnt_q;
  assign out_buf_id_o = buf_id_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_cnt_o  = frame_cnt_q;
  assign drop_cnt_o   = drop_cnt_q;
  assign len_err_o    = len_err_q;

endmodule

// File: tb/tb_pingpong_rd_sched.sv
// Directed bench for pingpong_rd_sched with a stub buffer read port and hand-derived expectations.
// Build with RD_SCHED_WDOG_EN defined to also exercise the stall watchdog.
module tb_pingpong_rd_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        buf_ready_i, buf_id_i, buf_take_o;
  logic [15:0] rd_data_i;
  logic        rd_valid_i, rd_last_i, rd_ready_o;
  logic [1:0]  req_i, gnt_o, out_valid_o, out_ready_i;
  logic [15:0] out_data_o;
  logic        out_last_o, out_buf_id_o, busy_o, len_err_o;
  logic [15:0] frame_cnt_o, drop_cnt_o;
`ifdef RD_SCHED_WDOG_EN
  logic        wdog_abort_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  pingpong_rd_sched #(
    .SAMPLE_W(16), .BUF_LEN(256), .NUM_CONS(2), .DROP_TMO(64), .CNT_W(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .buf_ready_i(buf_ready_i), .buf_id_i(buf_id_i), .buf_take_o(buf_take_o),
    .rd_data_i(rd_data_i), .rd_valid_i(rd_valid_i), .rd_last_i(rd_last_i), .rd_ready_o(rd_ready_o),
    .req_i(req_i), .gnt_o(gnt_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_last_o(out_last_o), .out_buf_id_o(out_buf_id_o), .busy_o(busy_o),
    .frame_cnt_o(frame_cnt_o), .drop_cnt_o(drop_cnt_o), .len_err_o(len_err_o)
`ifdef RD_SCHED_WDOG_EN
    , .wdog_abort_o(wdog_abort_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Raise buf_ready and count clock edges until buf_take is seen.
  task automatic start_take(input logic id, output int n);
    bit seen = 0;
    @(posedge clk_i); #1;
    buf_ready_i = 1'b1;
    buf_id_i    = id;
    n = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk_i);
      if (buf_take_o) seen = 1;
      else n++;
    end
    buf_ready_i = 1'b0;
    if (!seen) begin
      check("take_timeout", 0, 1);
      n = -1;
    end
  endtask

  // Stub buffer: offers 0x1000+i each cycle, checks every cycle's outputs, counts accepted beats.
  task automatic stream(input int len, input bit tog, input logic [1:0] eg, input bit disc,
                        input int max_beats, output int beats, output int errs);
    int  idx = 0;
    bit  done = 0;
    logic r;
    errs = 0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(posedge clk_i); #1;
      r           = tog ? (cyc % 2 == 1) : 1'b1;
      rd_valid_i  = 1'b1;
      rd_data_i   = 16'h1000 + 16'(idx);
      rd_last_i   = (idx == len - 1);
      out_ready_i = {2{r}};
      @(negedge clk_i);
      if (gnt_o !== eg) errs++;
      if (buf_take_o !== 1'b0) errs++;
      if (rd_ready_o !== (disc ? 1'b1 : r)) errs++;
      if (out_valid_o !== (disc ? 2'b00 : eg)) errs++;
      if (!disc && (out_data_o !== rd_data_i || out_last_o !== rd_last_i)) errs++;
      if (rd_ready_o) begin
        idx++;
        if (rd_last_i || (max_beats != 0 && idx == max_beats)) done = 1;
      end
    end
    if (!done) check("stream_timeout", 0, 1);
    beats = idx;
  endtask

  task automatic finish_frame(input logic [1:0] eg);
    @(posedge clk_i); #1;
    rd_valid_i = 1'b0;
    rd_last_i  = 1'b0;
    @(negedge clk_i);
    check("done_gnt", gnt_o, eg);
    @(negedge clk_i);
    check("idle_busy", busy_o, 0);
    check("idle_gnt", gnt_o, 0);
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1; rd_valid_i = 1'b0; rd_last_i = 1'b0; buf_ready_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    int n, beats, errs;
    rst_i = 1'b1; buf_ready_i = 0; buf_id_i = 0; rd_data_i = '0; rd_valid_i = 0;
    rd_last_i = 0; req_i = '0; out_ready_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_gnt", gnt_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_rd_ready", rd_ready_o, 0);
    check("rst_take", buf_take_o, 0);
    check("rst_frame_cnt", frame_cnt_o, 0);
    check("rst_drop_cnt", drop_cnt_o, 0);
    check("rst_len_err", len_err_o, 0);

    // Single consumer, full frame
    req_i = 2'b01;
    start_take(1'b1, n);
    check("t1_take_lat", n, 1);
    check("t1_gnt", gnt_o, 2'b01);
    @(posedge clk_i); #1;
    check("t1_buf_id", out_buf_id_o, 1);
    stream(256, 0, 2'b01, 0, 0, beats, errs);
    check("t1_beats", beats, 256);
    check("t1_errs", errs, 0);
    finish_frame(2'b01);
    check("t1_frame_cnt", frame_cnt_o, 1);
    check("t1_len_err", len_err_o, 0);

    // Two requesters alternate from a fresh pointer
    do_reset();
    req_i = 2'b11;
    for (int f = 0; f < 4; f++) begin
      start_take(f[0], n);
      check("t2_gnt", gnt_o, exp_g[f]);
      stream(256, 0, exp_g[f], 0, 0, beats, errs);
      check("t2_errs", errs, 0);
      finish_frame(exp_g[f]);
    end
    check("t2_frame_cnt", frame_cnt_o, 4);

    // No requester: discard after the timeout
    req_i = 2'b00;
    start_take(1'b0, n);
    check("t3_take_lat", n, 64);
    check("t3_gnt", gnt_o, 0);
    stream(256, 0, 2'b00, 1, 0, beats, errs);
    check("t3_beats", beats, 256);
    check("t3_errs", errs, 0);
    finish_frame(2'b00);
    check("t3_drop_cnt", drop_cnt_o, 1);
    check("t3_frame_cnt", frame_cnt_o, 4);

    // Owner ready toggles every cycle
    req_i = 2'b01;
    start_take(1'b1, n);
    stream(256, 1, 2'b01, 0, 0, beats, errs);
    check("t4_beats", beats, 256);
    check("t4_errs", errs, 0);
    finish_frame(2'b01);
    check("t4_frame_cnt", frame_cnt_o, 5);

    // Short frame sets sticky length error
    start_take(1'b0, n);
    stream(200, 0, 2'b01, 0, 0, beats, errs);
    check("t5_beats", beats, 200);
    check("t5_errs", errs, 0);
    finish_frame(2'b01);
    check("t5_len_err", len_err_o, 1);
    check("t5_frame_cnt", frame_cnt_o, 6);
    start_take(1'b1, n);
    stream(256, 0, 2'b01, 0, 0, beats, errs);
    finish_frame(2'b01);
    check("t5_len_err_sticky", len_err_o, 1);

    // Reset in the middle of a frame
    start_take(1'b0, n);
    stream(256, 0, 2'b01, 0, 100, beats, errs);
    check("t6_beats", beats, 100);
    do_reset();
    check("t6_gnt", gnt_o, 0);
    check("t6_rd_ready", rd_ready_o, 0);
    check("t6_busy", busy_o, 0);
    check("t6_frame_cnt", frame_cnt_o, 0);
    check("t6_drop_cnt", drop_cnt_o, 0);
    check("t6_len_err", len_err_o, 0);

`ifdef RD_SCHED_WDOG_EN
    begin
      int  stall = 0;
      bit  ab = 0;
      logic [1:0] v_at_abort = 2'b11;
      start_take(1'b0, n);
      for (int c = 0; c < 1100 && !ab; c++) begin
        @(posedge clk_i); #1;
        rd_valid_i = 1'b1; rd_data_i = 16'h1000; rd_last_i = 1'b0; out_ready_i = 2'b00;
        @(negedge clk_i);
        if (wdog_abort_o) begin
          ab = 1;
          v_at_abort = out_valid_o;
          rd_valid_i = 1'b0;
        end else begin
          stall++;
        end
      end
      check("wd_stall_cycles", stall, 1024);
      check("wd_abort", wdog_abort_o, 1);
      check("wd_valid_drop", v_at_abort, 0);
      stream(256, 0, 2'b01, 1, 0, beats, errs);
      check("wd_flush_errs", errs, 0);
      finish_frame(2'b01);
      check("wd_drop_cnt", drop_cnt_o, 1);
      check("wd_frame_cnt", frame_cnt_o, 0);
      check("wd_abort_sticky", wdog_abort_o, 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pingpong_rd_sched.md
Name: pingpong_rd_sched

Overview:
Read-side scheduler for the single-port ping-pong sample buffer.
- Watches buf_ready, pulses buf_take and drains each full buffer to one of NUM_CONS consumers.
- Consumers are chosen by round-robin arbitration.
- Ready buffers with no consumer claim are discarded after a timeout, so the writer never overruns.
- Sits between the buffer read port and the downstream processing blocks (FFT engine, debug dump).

Parameters:
SAMPLE_W, 16, sample width
BUF_LEN, 256, words per buffer; expected beat count per frame
NUM_CONS, 2, number of consumers (1..8)
DROP_TMO, 64, idle cycles with buf_ready high and no request before a buffer is discarded
CNT_W, 16, width of statistics counters

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; one clock; reset is synchronous and active-high
buf_ready_i  in  1  buffer holds a full frame
buf_id_i  in  1  id of the ready buffer
buf_take_o  out  1  one-cycle pulse claiming the ready buffer
rd_data_i  in  SAMPLE_W  buffer read data
rd_valid_i  in  1  read data valid
rd_last_i  in  1  final word of frame
rd_ready_o  out  1  read accept
req_i  in  NUM_CONS  consumer wants next frame (level)
gnt_o  out  NUM_CONS  one-hot owner of current frame
out_data_o  out  SAMPLE_W  shared data to consumers
out_valid_o  out  NUM_CONS  per-consumer valid, only owner bit may be set
out_ready_i  in  NUM_CONS  per-consumer ready
out_last_o  out  1  last beat of frame
out_buf_id_o  out  1  buf id latched at take
busy_o  out  1  state != IDLE
frame_cnt_o  out  CNT_W  frames delivered (saturating)
drop_cnt_o  out  CNT_W  frames discarded (saturating)
len_err_o  out  1  sticky; frame beat count != BUF_LEN

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; drop timer 0.
- FSM states: IDLE, TAKE, STREAM, DISCARD, DONE.
- IDLE:
  - If buf_ready_i and |req_i: grant the first requester at or after the rr pointer; latch gnt and buf_id_i; go to TAKE.
  - If buf_ready_i and no req: increment drop timer. When the timer reaches DROP_TMO-1, go to TAKE with a discard flag and gnt 0.
  - If buf_ready_i is low: the timer clears.
- TAKE: buf_take_o=1 for exactly this cycle; next state is STREAM, or DISCARD if the discard flag is set. gnt_o is asserted from TAKE through DONE.
- STREAM:
  - out_data_o=rd_data_i (combinational pass-through, zero added latency).
  - out_valid_o[owner]=rd_valid_i; rd_ready_o=out_ready_i[owner].
  - out_last_o=rd_last_i & rd_valid_i.
  - Each beat (rd_valid_i & rd_ready_o) increments the beat counter.
  - Beat with rd_last_i: go to DONE. If beat count incl. this beat != BUF_LEN, set len_err_o.
- DISCARD: rd_ready_o=1, out_valid_o=0; on a last beat, go to DONE and increment drop_cnt_o.
- DONE: one cycle.
  - gnt_o cleared on exit.
  - frame_cnt_o++ if not discard.
  - rr pointer = owner+1 mod NUM_CONS (unchanged after discard).
  - Return to IDLE. A buf_ready_i already high is evaluated on the IDLE cycle, giving minimum 2 idle-to-take cycles between frames.
- req_i deassertion during STREAM is ignored; the owner keeps the frame until last.
- Counters saturate at all-ones.
- Beat counter width is clog2(BUF_LEN+1). A runaway frame of more than BUF_LEN beats saturates the counter and sets len_err_o; it does not wrap.
- rst_i mid-frame: immediate return to IDLE with all outputs 0. The buffer is reset on the same domain reset.

Optional Feature:
Macro RD_SCHED_WDOG_EN.
- Defined:
  - In STREAM, a 16-bit watchdog counts consecutive cycles with rd_valid_i high and out_ready_i[owner] low.
  - At 1024 the frame is aborted: owner's out_valid drops and the state moves to DISCARD.
  - The rest of the frame is flushed and drop_cnt_o increments.
  - A sticky wdog_abort_o output port exists.
- Undefined: no watchdog, no port; a stalled owner holds the buffer indefinitely.

Decomposition:
- Package pingpong_pkg: state enum rd_sched_state_e, SAMPLE_W/BUF_LEN defaults, WDOG_LIMIT constant.
- One sub-module rr_arbiter (NUM_CONS req vector, pointer in, one-hot grant out, combinational) holds the arbitration logic.

Test Plan:
- Single consumer, req_i=1, stub buffer delivers 256 beats 0x1000+i with out_ready=1 -> buf_take 1 pulse, gnt_o=01, 256 beats match, out_last on beat 255, frame_cnt_o=1.
- Both consumers requesting, 4 frames -> grants alternate 01,10,01,10; frame_cnt_o=4.
- buf_ready high, req_i=0 for 64 cycles -> take on cycle 64, 256 beats drained with out_valid=0, drop_cnt_o=1, gnt_o stays 0.
- Owner out_ready toggles 50% -> rd_ready_o mirrors it, no beats lost or duplicated, data order intact.
- Stub frame with rd_last on beat 200 -> DONE after 200 beats, len_err_o=1 sticky until reset.
- rst_i pulsed at beat 100 -> next cycle gnt_o=0, rd_ready_o=0, busy_o=0, counters 0. With RD_SCHED_WDOG_EN, owner ready held low 1024 cycles -> wdog_abort_o=1, drop_cnt_o=1.
